// File: rtl/param_systolic_array_if.sv
// Job-side and result-side handshake bundle for param_systolic_array.
// The slave modport is the array's view; master is the driver/consumer view.
interface param_systolic_array_if #(
  parameter int unsigned DIM    = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned KW     = 8
);
  localparam int unsigned IDX_W = $clog2(DIM);

  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [DIM*DATA_W-1:0]   a_vec;
  logic [DIM*DATA_W-1:0]   b_vec;
  logic                    out_valid;
  logic                    out_ready;
  logic [DIM*ACC_W-1:0]    out_row;
  logic [IDX_W-1:0]        out_row_idx;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done
  );

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done
  );
endinterface

// File: rtl/param_systolic_array.sv
// DIM x DIM output-stationary MAC array computing C = A x B with input skew,
// a feed/flush/readout controller and valid/ready handshakes on both sides.
module param_systolic_array #(
  parameter int unsigned DIM    = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned KW     = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   init_n,
  param_systolic_array_if.slave  bus
);

  localparam int unsigned IDX_W     = $clog2(DIM);
  localparam int unsigned PW        = 2 * DATA_W;
  localparam int unsigned FLUSH_CYC = 2 * DIM - 1;
  localparam int unsigned FW        = $clog2(2 * DIM);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          kcnt_q, kcnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DIM*ACC_W-1:0]   out_row_q, out_row_d;
  logic [IDX_W-1:0]       row_q, row_d;

  logic step_acc_c, row_acc_c, last_row_c, clr_c, adv_c;

  logic [DATA_W-1:0] a_src [DIM];
  logic [DATA_W-1:0] b_src [DIM];
  logic [DATA_W-1:0] a_sk  [DIM];
  logic [DATA_W-1:0] b_sk  [DIM];
  logic [DATA_W-1:0] a_in  [DIM][DIM];
  logic [DATA_W-1:0] b_in  [DIM][DIM];
  logic [DATA_W-1:0] a_q   [DIM][DIM-1];
  logic [DATA_W-1:0] b_q   [DIM-1][DIM];
  logic [ACC_W-1:0]  acc_q [DIM][DIM];

  assign step_acc_c = (state_q == FEED) && bus.in_valid;
  assign row_acc_c  = (state_q == OUT) && out_valid_q && bus.out_ready;
  assign last_row_c = (row_q == IDX_W'(DIM - 1));
  assign clr_c      = (state_q == IDLE) && bus.start;
  assign adv_c      = step_acc_c || (state_q == FLUSH);

  // Product extended to the accumulator width according to operand signedness.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [PW-1:0] p;
    if (SIGNED != 0) begin
      p = PW'($signed(a)) * PW'($signed(b));
      return ACC_W'($signed(p));
    end else begin
      p = PW'(a) * PW'(b);
      return ACC_W'(p);
    end
  endfunction

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          kcnt_d  = bus.k_len;
          state_d = (bus.k_len != '0) ? FEED : OUT;
        end
      end
      FEED: begin
        if (step_acc_c) begin
          kcnt_d = kcnt_q - KW'(1);
          if (kcnt_q == KW'(1)) begin
            state_d = FLUSH;
            fcnt_d  = '0;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FW'(FLUSH_CYC - 1)) state_d = OUT;
        else                              fcnt_d  = fcnt_q + FW'(1);
      end
      OUT: begin
        if (row_acc_c && last_row_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state.
  always_comb begin
    logic load;
    in_ready_d  = (state_d == FEED);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
    done_d      = 1'b0;
    out_row_d   = out_row_q;
    row_d       = row_q;
    load        = 1'b0;
    if (state_q != OUT && state_d == OUT) begin
      row_d = '0;
      // From IDLE the accumulators clear on this same edge, so present zeros.
      if (state_q == IDLE) out_row_d = '0;
      else                 load      = 1'b1;
    end else if (row_acc_c) begin
      if (last_row_c) begin
        done_d = 1'b1;
      end else begin
        row_d = row_q + IDX_W'(1);
        load  = 1'b1;
      end
    end
    if (load) begin
      for (int j = 0; j < DIM; j++) out_row_d[j*ACC_W +: ACC_W] = acc_q[row_d][j];
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      kcnt_q      <= '0;
      fcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_row_q   <= '0;
      row_q       <= '0;
    end else begin
      kcnt_q      <= kcnt_d;
      fcnt_q      <= fcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_row_q   <= out_row_d;
      row_q       <= row_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = row_q;

  // Row/column g is delayed by g advances; zeros are injected outside FEED.
  for (genvar g = 0; g < DIM; g++) begin : g_skew
    assign a_src[g] = (state_q == FEED) ? bus.a_vec[g*DATA_W +: DATA_W] : '0;
    assign b_src[g] = (state_q == FEED) ? bus.b_vec[g*DATA_W +: DATA_W] : '0;
    if (g == 0) begin : g_direct
      assign a_sk[g] = a_src[g];
      assign b_sk[g] = b_src[g];
    end else begin : g_delay
      logic [DATA_W-1:0] ad_q [g];
      logic [DATA_W-1:0] bd_q [g];
      always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
          for (int s = 0; s < g; s++) begin
            ad_q[s] <= '0;
            bd_q[s] <= '0;
          end
        end else if (clr_c) begin
          for (int s = 0; s < g; s++) begin
            ad_q[s] <= '0;
            bd_q[s] <= '0;
          end
        end else if (adv_c) begin
          ad_q[0] <= a_src[g];
          bd_q[0] <= b_src[g];
          for (int s = 1; s < g; s++) begin
            ad_q[s] <= ad_q[s-1];
            bd_q[s] <= bd_q[s-1];
          end
        end
      end
      assign a_sk[g] = ad_q[g-1];
      assign b_sk[g] = bd_q[g-1];
    end
  end

  // Operand routing: a enters at column 0 and moves right, b enters at row 0 and moves down.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_sk[gi];
      end else begin : g_a_pipe
        assign a_in[gi][gj] = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_sk[gj];
      end else begin : g_b_pipe
        assign b_in[gi][gj] = b_q[gi-1][gj];
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) acc_q[i][j] <= '0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM - 1; j++) a_q[i][j] <= '0;
      for (int i = 0; i < DIM - 1; i++)
        for (int j = 0; j < DIM; j++) b_q[i][j] <= '0;
    end else if (clr_c) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) acc_q[i][j] <= '0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM - 1; j++) a_q[i][j] <= '0;
      for (int i = 0; i < DIM - 1; i++)
        for (int j = 0; j < DIM; j++) b_q[i][j] <= '0;
    end else if (adv_c) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++)
          acc_q[i][j] <= acc_q[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM - 1; j++) a_q[i][j] <= a_in[i][j];
      for (int i = 0; i < DIM - 1; i++)
        for (int j = 0; j < DIM; j++) b_q[i][j] <= b_in[i][j];
    end
  end

endmodule

// File: tb/tb_param_systolic_array.sv
// Directed bench for param_systolic_array: an unsigned and a signed instance
// share one stimulus stream and are checked against hand-computed results.
module tb_param_systolic_array;

  localparam int unsigned DIM    = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned KW     = 8;
  localparam int unsigned IDX_W  = $clog2(DIM);
  localparam int unsigned RW     = DIM * ACC_W;

  typedef struct {
    int                k;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] b_c;
    bit                ident;
    bit                stall;
    bit                noise;
    int                hold_row;
    int                hold_len;
    logic [ACC_W-1:0]  exp_u;
    logic [ACC_W-1:0]  exp_s;
    int                rs;
    int                cs;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  init_n;
  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  in_valid;
  logic [DIM*DATA_W-1:0] a_vec;
  logic [DIM*DATA_W-1:0] b_vec;
  logic                  out_ready;

  int n_vec = 0;
  int n_bad = 0;

  vec_t  vt [6];
  string nm [6];

  always #5 clk = ~clk;

  param_systolic_array_if #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .KW(KW)) bus_u ();
  param_systolic_array_if #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .KW(KW)) bus_s ();

  assign bus_u.start     = start;
  assign bus_u.k_len     = k_len;
  assign bus_u.in_valid  = in_valid;
  assign bus_u.a_vec     = a_vec;
  assign bus_u.b_vec     = b_vec;
  assign bus_u.out_ready = out_ready;
  assign bus_s.start     = start;
  assign bus_s.k_len     = k_len;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.a_vec     = a_vec;
  assign bus_s.b_vec     = b_vec;
  assign bus_s.out_ready = out_ready;

  param_systolic_array #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .KW(KW), .SIGNED(0)) dut_u (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus_u.slave)
  );

  param_systolic_array #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .KW(KW), .SIGNED(1)) dut_s (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus_s.slave)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input vec_t v, input int r, input bit sgn);
    logic [RW-1:0] row;
    for (int j = 0; j < DIM; j++)
      row[j*ACC_W +: ACC_W] = (sgn ? v.exp_s : v.exp_u) + ACC_W'(r * v.rs + j * v.cs);
    return row;
  endfunction

  task automatic drive_step(input vec_t v, input int s);
    for (int i = 0; i < DIM; i++) begin
      a_vec[i*DATA_W +: DATA_W] = v.ident ? ((i == s) ? DATA_W'(1) : DATA_W'(0)) : v.a_c;
      b_vec[i*DATA_W +: DATA_W] = v.ident ? DATA_W'(10 * s + i) : v.b_c;
    end
  endtask

  task automatic fill_junk();
    for (int i = 0; i < DIM; i++) begin
      a_vec[i*DATA_W +: DATA_W] = DATA_W'(5);
      b_vec[i*DATA_W +: DATA_W] = DATA_W'(5);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int step, cyc, lat, hold;
    bit iv;
    @(negedge clk);
    start    = 1'b1;
    k_len    = KW'(v.k);
    in_valid = v.noise;
    if (v.noise) fill_junk();
    @(negedge clk);
    start = 1'b0;
    step  = 0;
    cyc   = 0;
    if (v.k > 0) begin
      while (step < v.k && cyc < 200) begin
        iv       = v.stall ? (cyc % 2 == 0) : 1'b1;
        in_valid = iv;
        drive_step(v, step);
        start    = v.noise && !iv;
        k_len    = (v.noise && !iv) ? KW'(7) : KW'(v.k);
        if (iv && bus_u.in_ready) step++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk({tag, " steps accepted"}, RW'(step), RW'(v.k));
      chk({tag, " in_ready after feed"}, RW'(bus_u.in_ready), RW'(1'b0));
      chk({tag, " busy in flush"}, RW'(bus_u.busy), RW'(1'b1));
      lat = 1;
      while (!bus_u.out_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk({tag, " latency"}, RW'(lat), RW'(2 * DIM));
    end
    chk({tag, " out_valid u"}, RW'(bus_u.out_valid), RW'(1'b1));
    chk({tag, " out_valid s"}, RW'(bus_s.out_valid), RW'(1'b1));
    for (int r = 0; r < DIM; r++) begin
      hold = (r == v.hold_row) ? v.hold_len : 0;
      for (int h = 0; h <= hold; h++) begin
        chk($sformatf("%s row%0d u", tag, r), RW'(bus_u.out_row), exp_row(v, r, 1'b0));
        chk($sformatf("%s row%0d s", tag, r), RW'(bus_s.out_row), exp_row(v, r, 1'b1));
        chk($sformatf("%s idx%0d", tag, r), RW'(bus_u.out_row_idx), RW'(r));
        chk($sformatf("%s valid%0d", tag, r), RW'(bus_u.out_valid), RW'(1'b1));
        chk($sformatf("%s early done%0d", tag, r), RW'(bus_u.done), RW'(1'b0));
        out_ready = (h == hold);
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
    chk({tag, " done u"}, RW'(bus_u.done), RW'(1'b1));
    chk({tag, " done s"}, RW'(bus_s.done), RW'(1'b1));
    chk({tag, " valid drop"}, RW'(bus_u.out_valid), RW'(1'b0));
    chk({tag, " idle"}, RW'(bus_u.busy), RW'(1'b0));
    @(negedge clk);
    chk({tag, " done pulse"}, RW'(bus_u.done), RW'(1'b0));
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    vt[0] = '{k:5, a_c:0, b_c:0, ident:1, stall:0, noise:0, hold_row:-1, hold_len:0,
              exp_u:64'd0, exp_s:64'd0, rs:10, cs:1};
    vt[1] = '{k:3, a_c:2, b_c:3, ident:0, stall:1, noise:1, hold_row:-1, hold_len:0,
              exp_u:64'd18, exp_s:64'd18, rs:0, cs:0};
    vt[2] = '{k:3, a_c:2, b_c:3, ident:0, stall:1, noise:0, hold_row:1, hold_len:4,
              exp_u:64'd18, exp_s:64'd18, rs:0, cs:0};
    vt[3] = '{k:2, a_c:32'hFFFF_FFFF, b_c:7, ident:0, stall:0, noise:0, hold_row:-1, hold_len:0,
              exp_u:64'h0000_000D_FFFF_FFF2, exp_s:64'hFFFF_FFFF_FFFF_FFF2, rs:0, cs:0};
    vt[4] = '{k:0, a_c:0, b_c:0, ident:0, stall:0, noise:1, hold_row:-1, hold_len:0,
              exp_u:64'd0, exp_s:64'd0, rs:0, cs:0};
    vt[5] = '{k:1, a_c:1, b_c:1, ident:0, stall:0, noise:0, hold_row:-1, hold_len:0,
              exp_u:64'd1, exp_s:64'd1, rs:0, cs:0};
    nm = '{"identity", "stalled", "out_hold", "minus_one", "k_zero", "after_reset"};

    init_n    = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    out_ready = 1'b0;
    #12;
    chk("reset in_ready", RW'(bus_u.in_ready), RW'(1'b0));
    chk("reset out_valid", RW'(bus_u.out_valid), RW'(1'b0));
    chk("reset busy", RW'(bus_u.busy), RW'(1'b0));
    chk("reset done", RW'(bus_u.done), RW'(1'b0));
    chk("reset out_row", RW'(bus_u.out_row), RW'(0));
    chk("reset out_row_idx", RW'(bus_u.out_row_idx), RW'(0));
    @(negedge clk);
    init_n = 1'b1;

    for (int t = 0; t < 5; t++) run_job(vt[t], nm[t]);

    // Abandon a job part-way through FLUSH.
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      drive_step(vt[1], s);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset busy", RW'(bus_u.busy), RW'(1'b1));
    init_n = 1'b0;
    #1;
    chk("mid-job reset busy", RW'(bus_u.busy), RW'(1'b0));
    chk("mid-job reset in_ready", RW'(bus_u.in_ready), RW'(1'b0));
    chk("mid-job reset out_valid", RW'(bus_u.out_valid), RW'(1'b0));
    chk("mid-job reset busy s", RW'(bus_s.busy), RW'(1'b0));
    @(negedge clk);
    init_n = 1'b1;
    seen   = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus_u.done || bus_u.out_valid || bus_u.busy) seen = 1'b1;
    end
    chk("abandoned job activity", RW'(seen), RW'(1'b0));

    run_job(vt[5], nm[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
